// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants and small helpers.
// Used by every fetch-stage file.
package arm_pkg;

  localparam int WORD_BYTES  = 4;
  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK       = ~PC_WIDTH'(WORD_BYTES - 1);

  // Drop the byte offset so the result is always a word address.
  function automatic logic [PC_WIDTH-1:0] align_word(input logic [PC_WIDTH-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter storage with synchronous active-low reset,
// load enable and parallel load.
module pc_register
  import arm_pkg::*;
#(
  parameter int                 WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg <= RESET_VALUE;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, drives the instruction memory address and
// registers the fetched word into the IF/ID pipeline register.
module instruction_fetch_unit
  import arm_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_address,
  output logic [PC_WIDTH-1:0]    imem_address,
  input  logic [INSTR_WIDTH-1:0] imem_instruction,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instruction_out,
  output logic                   valid_out
);

  // A misaligned RESET_PC is silently forced onto a word boundary.
  localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = align_word(RESET_PC);

  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    pc_plus4;
  logic [PC_WIDTH-1:0]    pc_next;
  logic                   pc_en;

  logic [PC_WIDTH-1:0]    pc_out_reg;
  logic [INSTR_WIDTH-1:0] instruction_out_reg;
  logic                   valid_out_reg;

  assign pc_plus4 = pc + PC_WIDTH'(WORD_BYTES);
  assign pc_next  = branch_taken ? align_word(branch_address) : pc_plus4;
  // A branch must still redirect while the hazard unit is freezing us.
  assign pc_en    = ~freeze | branch_taken;

  pc_register #(
    .WIDTH       (PC_WIDTH),
    .RESET_VALUE (RESET_PC_ALIGNED)
  ) u_pc_register (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_next),
    .q   (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_out_reg          <= '0;
      instruction_out_reg <= '0;
      valid_out_reg       <= 1'b0;
    end else if (branch_taken) begin
      // Flush the wrong-path word fetched this cycle.
      pc_out_reg          <= '0;
      instruction_out_reg <= '0;
      valid_out_reg       <= 1'b0;
    end else if (!freeze) begin
      pc_out_reg          <= pc_plus4;
      instruction_out_reg <= imem_instruction;
      valid_out_reg       <= 1'b1;
    end
  end

  assign imem_address    = pc;
  assign pc_out          = pc_out_reg;
  assign instruction_out = instruction_out_reg;
  assign valid_out       = valid_out_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a reference model pushes
// the expected post-edge state on each drive; it is popped and compared after the edge.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_address;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;

  typedef struct {
    logic [31:0] imem;
    logic [31:0] pc_out;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  logic [31:0] m_pc, m_pc_out, m_instr;
  logic        m_valid;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .branch_taken     (branch_taken),
    .branch_address   (branch_address),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .pc_out           (pc_out),
    .instruction_out  (instruction_out),
    .valid_out        (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr >> 2;
    if (idx == 32'd0) return 32'hE3A01A01;
    if (idx == 32'd1) return 32'hE3A00014;
    return 32'hE1A00000 ^ (idx * 32'h0101_0107);
  endfunction

  assign imem_instruction = mem_word(imem_address);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, advance the model, push, clock, pop, compare.
  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
    exp_t e, o;
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_address = ba;
    if (!r) begin
      m_pc = RESET_PC & ~32'h3; m_pc_out = '0; m_instr = '0; m_valid = 1'b0;
    end else if (b) begin
      m_pc = ba & ~32'h3; m_pc_out = '0; m_instr = '0; m_valid = 1'b0;
    end else if (!f) begin
      m_pc_out = m_pc + 32'd4; m_instr = mem_word(m_pc); m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    e.imem = m_pc; e.pc_out = m_pc_out; e.instr = m_instr; e.valid = m_valid;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    txn++;
    $display("txn %0d rst=%0b frz=%0b br=%0b ba=%08h | imem=%08h pc_out=%08h instr=%08h valid=%0b",
             txn, r, f, b, ba, imem_address, pc_out, instruction_out, valid_out);
    check("imem_address", imem_address, o.imem);
    check("pc_out", pc_out, o.pc_out);
    check("instruction_out", instruction_out, o.instr);
    check("valid_out", {31'd0, valid_out}, {31'd0, o.valid});
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
    m_pc = '0; m_pc_out = '0; m_instr = '0; m_valid = 1'b0;

    // Reset for two cycles
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check("reset_imem", imem_address, 32'h0);

    // Sequential fetch
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("seq1_pc_out", pc_out, 32'h4);
    check("seq1_instr", instruction_out, 32'hE3A01A01);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("seq2_pc_out", pc_out, 32'h8);
    check("seq2_instr", instruction_out, 32'hE3A00014);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("seq3_imem", imem_address, 32'hC);

    // Freeze for three cycles at 12
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("freeze_imem", imem_address, 32'hC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("unfreeze_pc_out", pc_out, 32'h10);
    check("unfreeze_instr", instruction_out, mem_word(32'hC));

    // Branch with misaligned target
    step(1'b1, 1'b0, 1'b1, 32'h0000_0043);
    check("br_imem", imem_address, 32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("br_pc_out", pc_out, 32'h44);
    check("br_instr", instruction_out, mem_word(32'h40));

    // Branch wins over freeze
    step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
    check("brfrz_imem", imem_address, 32'h100);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Wrap around the top of the address space
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_imem", imem_address, 32'h0);
    check("wrap_pc_out", pc_out, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Reset during freeze
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("rstfrz_valid", {31'd0, valid_out}, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Randomised mix
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), $urandom);
    end

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
